mem_responder: RTL and testbench
================================

# mem_responder

Memory-side endpoint of the serial TX/RX link driven by the CPU scheduler. Deserializes TX messages (start, header, 16-bit address, optional 16-bit write data) arriving NSHIFT bits per cycle. Performs the access on a 16-bit synchronous memory port. For reads, serializes an RX reply back to the CPU. It sits between the CPU's TX/RX pins and the RAM/peripheral bus.

## Interface
Parameters:
- NSHIFT, 2, bits per link cycle in each direction; only 2 is supported.
- PAYLOAD_CYCLES, 8, link cycles per 16-bit payload; must equal 16/NSHIFT.
- ADDR_BITS, 15, memory word-address width; the word address is byte address [15:1].

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high.
- tx_pins  in  NSHIFT  CPU→responder link; idle value 2'b00.
- rx_pins  out  NSHIFT  responder→CPU link; idle value 2'b00.
- mem_addr  out  ADDR_BITS  word address.
- mem_re  out  1  read strobe; mem_rdata is valid the next cycle.
- mem_we  out  1  write strobe.
- mem_be  out  2  byte enables: [0] is low byte (even address), [1] is high byte.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data.
- busy  out  1  high while a TX message is being received or a reply is pending or being sent.
- err_hdr  out  1  one-cycle pulse when a message with the reserved header completes.

## Operation
- RX-of-TX state machine: IDLE → HEADER → ADDR → (DATA) → IDLE.
  - IDLE: tx_pins[0]==1 is the start cycle; go to HEADER.
  - HEADER: latch tx_pins as the header. 2'b00 = READ_16, 2'b01 = WRITE_8, 2'b10 = WRITE_16, 2'b11 = reserved.
  - ADDR: 8 cycles shifting in address bits, LSB first. Cycle k carries bits [2k+1:2k].
  - READ_16 and reserved go to IDLE after ADDR. Writes enter DATA for 8 cycles, same bit order; WRITE_8 uses only bits [7:0].
  - A new start is accepted in the first cycle back in IDLE.
- Read access: mem_re=1 for one cycle with mem_addr=addr[15:1]. Address bit 0 is ignored for 16-bit accesses. mem_rdata is captured the following cycle into the reply register.
- Write access: mem_we=1 for one cycle.
  - WRITE_16: mem_be=2'b11, mem_wdata=data.
  - WRITE_8: mem_be = addr[0] ? 2'b10 : 2'b01, with the data byte replicated on both halves of mem_wdata.
- Reserved header: the payload is consumed, with no memory access and no reply. err_hdr pulses in the cycle after the last ADDR cycle.
- Reply transmitter: drives one start cycle (rx_pins=2'b01), then 8 data cycles, LSB first. It returns rx_pins to 2'b00 afterwards.
- If captured reply data becomes ready while a reply is still being sent, it waits in a 1-entry holding register. It starts in the cycle after the current reply's last data cycle. A further capture while the holding register is full overwrites it and pulses err_hdr.
- Strobe and reply-register outputs are registered. mem_addr, mem_be and mem_wdata are don't-care when no strobe is active.

## Timing
- Let T0 be the start cycle. T1 is the header and T2..T9 are the address.
- READ_16:
  - mem_re at T10, capture at T11.
  - rx_pins start cycle at T12, data at T13..T20.
  - Next TX start is accepted at T10.
- Writes: data arrives T10..T17, mem_we at T18, next TX start is accepted at T18.
- Back-to-back reads with zero gap never need the holding register.
- Reset values: rx_pins=0, mem_re=0, mem_we=0, mem_be=0, busy=0, err_hdr=0, state=IDLE, holding register empty.
- Reset mid-message: the partial message is discarded and no strobe is issued. An in-flight reply is aborted, with rx_pins=0 in the cycle after reset.

## Configuration
- MEM_RESP_SWAP_REPLY_EN defined:
  - Writes also issue mem_re at T10 for the same word and capture the old contents at T11.
  - They send those contents as an RX reply starting at T12, before the mem_we at T18. This supports swap instructions.
  - WRITE_8 replies with the full 16-bit old word.
- Not defined: writes produce no mem_re and no reply.

## Test plan
- READ_16 of address 0x1234, with word 0x091A holding 0xBEEF:
  - mem_re at T10 with mem_addr=0x091A.
  - rx_pins = 01 at T12, then 3,3,2,3,2,3,3,2 at T13..T20, then 0.
- WRITE_8 of address 0x0021 with data 0x5A: mem_we at T18, mem_addr=0x0010, mem_be=2'b10, mem_wdata[15:8]=0x5A; no reply.
- Reserved header 2'b11: err_hdr pulses at T10; no mem_re or mem_we; rx_pins stays 0; a following READ_16 started at T10 is served normally.
- Reset asserted at T5 of a WRITE_16: no mem_we ever; busy=0 after reset; a READ_16 started 2 cycles later replies at its own T12.
- Two READ_16 messages back to back (second start at T10): replies occupy T12..T20 and T22..T30, with no err_hdr.
- With MEM_RESP_SWAP_REPLY_EN: WRITE_16 of 0x1111 to a word holding 0x2222 replies with 0x2222 and leaves the word holding 0x1111. Without the macro: no reply.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: memory-side endpoint of the serial TX/RX link.
//
// Receives TX messages from the CPU scheduler NSHIFT bits per cycle:
//   start (tx_pins[0]==1 while idle), header, 16-bit byte address (LSB pair
//   first), and for writes 16 bits of write data in the same order.
// Performs the access on a 16-bit synchronous memory port and, for reads,
// sends an RX reply: one start cycle (rx_pins=01) then the 16-bit word in
// PAYLOAD_CYCLES cycles, LSB pair first.
//
// Link protocol: there is no valid/ready pair. A transfer is framed purely
// by time: a start cycle, then a fixed number of payload cycles that the
// receiver must accept unconditionally. Idle value on both links is 00.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   tx_pins         CPU->responder link
//   rx_pins         responder->CPU link (registered)
//   mem_addr        word address (byte address [15:1])
//   mem_re          read strobe, mem_rdata valid the following cycle
//   mem_we          write strobe
//   mem_be          byte enables ([0] = low/even byte)
//   mem_wdata       write data
//   mem_rdata       read data
//   busy            message in reception or reply pending/being sent
//   err_hdr         pulse: reserved header completed, or reply overwritten
//   dbg_state       receive FSM state (debug)
//
// Optional feature: define MEM_RESP_SWAP_REPLY_EN to make writes also read
// the old word and return it as a reply (swap support).

module mem_responder #(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int ADDR_BITS      = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSHIFT-1:0]    tx_pins,
  output logic [NSHIFT-1:0]    rx_pins,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_re,
  output logic                 mem_we,
  output logic [1:0]           mem_be,
  output logic [15:0]          mem_wdata,
  input  logic [15:0]          mem_rdata,
  output logic                 busy,
  output logic                 err_hdr,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W  = $clog2(PAYLOAD_CYCLES);
  localparam int LEFT_W = $clog2(PAYLOAD_CYCLES + 1);

  localparam logic [1:0] HDR_READ16  = 2'b00;
  localparam logic [1:0] HDR_WRITE8  = 2'b01;
  localparam logic [1:0] HDR_WRITE16 = 2'b10;
  localparam logic [1:0] HDR_RSVD    = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_ADDR   = 2'd2,
    S_DATA   = 2'd3
  } state_e;

  // Receive side
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]             hdr_q, hdr_d;
  logic [15-NSHIFT:0]     pay_q, pay_d;
  logic [15:0]            addr_q, addr_d;
  logic [15:0]            shift_in;
  logic                   cnt_last;

  // Memory strobes
  logic                   mem_re_q, mem_re_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]             mem_be_q, mem_be_d;
  logic [15:0]            mem_wdata_q, mem_wdata_d;
  logic                   err_q, err_d;
  logic                   err_fsm, err_ovf;

  // Reply side
  logic                   rd_pend_q, rd_pend_d;
  logic [NSHIFT-1:0]      rx_q, rx_d;
  logic [15:0]            rsh_q, rsh_d;
  logic [LEFT_W-1:0]      left_q, left_d;
  logic                   act_q, act_d;
  logic [15:0]            hold_q, hold_d;
  logic                   hv_q, hv_d;

  // New payload bits enter at the top, so after PAYLOAD_CYCLES shifts the
  // first-received pair sits at [NSHIFT-1:0].
  assign shift_in = {tx_pins, pay_q};
  assign cnt_last = (cnt_q == CNT_W'(PAYLOAD_CYCLES - 1));

  // Receive FSM and access generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_d       = hdr_q;
    pay_d       = pay_q;
    addr_d      = addr_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    err_fsm     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_pins[0]) state_d = S_HEADER;
      end
      S_HEADER: begin
        hdr_d   = tx_pins[1:0];
        cnt_d   = '0;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        pay_d = shift_in[15:NSHIFT];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last) begin
          addr_d     = shift_in;
          cnt_d      = '0;
          mem_addr_d = shift_in[ADDR_BITS:1];
          case (hdr_q)
            HDR_READ16: begin
              mem_re_d = 1'b1;
              state_d  = S_IDLE;
            end
            HDR_RSVD: begin
              err_fsm = 1'b1;
              state_d = S_IDLE;
            end
            default: begin
`ifdef MEM_RESP_SWAP_REPLY_EN
              // Fetch the old word so it can be returned before the write.
              mem_re_d = 1'b1;
`endif
              state_d = S_DATA;
            end
          endcase
        end
      end
      S_DATA: begin
        pay_d = shift_in[15:NSHIFT];
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last) begin
          cnt_d      = '0;
          state_d    = S_IDLE;
          mem_we_d   = 1'b1;
          mem_addr_d = addr_q[ADDR_BITS:1];
          if (hdr_q == HDR_WRITE16) begin
            mem_be_d    = 2'b11;
            mem_wdata_d = shift_in;
          end else begin
            // Byte write: replicate so the enabled lane always sees the byte.
            mem_be_d    = addr_q[0] ? 2'b10 : 2'b01;
            mem_wdata_d = {shift_in[7:0], shift_in[7:0]};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reply transmitter. left_q counts data cycles still to be sent after the
  // current one; the transmitter can start a new reply once it reaches 0.
  always_comb begin
    rd_pend_d = mem_re_q;
    rx_d      = '0;
    rsh_d     = rsh_q;
    left_d    = left_q;
    act_d     = 1'b0;
    hold_d    = hold_q;
    hv_d      = hv_q;
    err_ovf   = 1'b0;

    if (left_q != '0) begin
      rx_d   = rsh_q[NSHIFT-1:0];
      rsh_d  = {{NSHIFT{1'b0}}, rsh_q[15:NSHIFT]};
      left_d = left_q - LEFT_W'(1);
      act_d  = 1'b1;
      if (rd_pend_q) begin
        err_ovf = hv_q;
        hold_d  = mem_rdata;
        hv_d    = 1'b1;
      end
    end else if (hv_q) begin
      // Held reply goes first; a simultaneous capture takes its place.
      rx_d   = NSHIFT'(1);
      rsh_d  = hold_q;
      left_d = LEFT_W'(PAYLOAD_CYCLES);
      act_d  = 1'b1;
      hv_d   = 1'b0;
      if (rd_pend_q) begin
        hold_d = mem_rdata;
        hv_d   = 1'b1;
      end
    end else if (rd_pend_q) begin
      rx_d   = NSHIFT'(1);
      rsh_d  = mem_rdata;
      left_d = LEFT_W'(PAYLOAD_CYCLES);
      act_d  = 1'b1;
    end

    err_d = err_fsm | err_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hdr_q       <= '0;
      pay_q       <= '0;
      addr_q      <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      rx_q        <= '0;
      rsh_q       <= '0;
      left_q      <= '0;
      act_q       <= 1'b0;
      hold_q      <= '0;
      hv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_q       <= hdr_d;
      pay_q       <= pay_d;
      addr_q      <= addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      rd_pend_q   <= rd_pend_d;
      rx_q        <= rx_d;
      rsh_q       <= rsh_d;
      left_q      <= left_d;
      act_q       <= act_d;
      hold_q      <= hold_d;
      hv_q        <= hv_d;
    end
  end

  assign rx_pins   = rx_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign err_hdr   = err_q;
  assign busy      = (state_q != S_IDLE) | mem_re_q | rd_pend_q | act_q | hv_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int N = 2000;
`ifdef MEM_RESP_SWAP_REPLY_EN
  localparam bit SWAP = 1'b1;
`else
  localparam bit SWAP = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  tx_pins;
  logic [1:0]  rx_pins;
  logic [14:0] mem_addr;
  logic        mem_re, mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        busy, err_hdr;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  mem_responder dut (
    .clk(clk), .reset(reset), .tx_pins(tx_pins), .rx_pins(rx_pins),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy),
    .err_hdr(err_hdr), .dbg_state(dbg_state)
  );

  // ---------------- memory environment ----------------
  logic [15:0] seed;
  logic [15:0] ram     [0:32767];
  logic [15:0] ref_mem [0:32767];
  bit          loaded = 1'b0;

  function automatic logic [15:0] init_word(input int a);
    if (a == 'h091A) return 16'hBEEF;
    if (a == 'h0280) return 16'h2222;
    return 16'(a * 40503) ^ seed;
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 32768; i++) ram[i] <= init_word(i);
      loaded <= 1'b1;
    end else begin
      if (mem_we) begin
        if (mem_be[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
        if (mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
      end
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  // ---------------- timeline: stimulus and model expectations ----------------
  logic [1:0]  tx_arr   [N];
  bit          rst_arr  [N];
  logic [1:0]  exp_rx   [N];
  bit          exp_re   [N];
  bit          exp_we   [N];
  bit          exp_err  [N];
  bit          exp_busy [N];
  logic [14:0] exp_addr [N];
  logic [1:0]  exp_be   [N];
  logic [15:0] exp_wdata[N];
  logic [15:0] exp_q[$];
  int          last_end = -100;
  int          checks = 0;
  int          failures = 0;
  int          end_cyc;

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  // A reply whose word was captured at cycle c: starts the cycle after
  // capture, or after the previous reply's last data cycle if that is later.
  task automatic sched_reply(input int c, input logic [15:0] w);
    int s;
    s = (c + 1 > last_end + 1) ? c + 1 : last_end + 1;
    exp_rx[s] = 2'b01;
    for (int k = 0; k < 8; k++) exp_rx[s + 1 + k] = w[2*k +: 2];
    for (int x = c - 1; x <= s + 8; x++) exp_busy[x] = 1'b1;
    last_end = s + 8;
    exp_q.push_back(w);
  endtask

  // Message starting at t0; trunc!=0 asserts reset during cycle trunc.
  task automatic add_msg(input int t0, input logic [1:0] hdr, input logic [15:0] addr,
                         input logic [15:0] data, input int trunc);
    logic [1:0]  seq [18];
    logic [14:0] word;
    logic [15:0] old;
    bit          is_wr;
    int          last_in, stop;
    is_wr   = (hdr == 2'b01) || (hdr == 2'b10);
    last_in = is_wr ? t0 + 17 : t0 + 9;
    seq[0]  = {1'($urandom_range(0, 1)), 1'b1};
    seq[1]  = hdr;
    for (int k = 0; k < 8; k++) begin
      seq[2 + k]  = addr[2*k +: 2];
      seq[10 + k] = data[2*k +: 2];
    end
    stop = (trunc != 0) ? trunc : last_in;
    for (int i = t0; i <= stop; i++) tx_arr[i] = seq[i - t0];
    for (int x = t0 + 1; x <= stop; x++) exp_busy[x] = 1'b1;
    if (trunc != 0) begin
      rst_arr[trunc] = 1'b1;
      return;
    end
    word = addr[15:1];
    if (hdr == 2'b11) exp_err[t0 + 10] = 1'b1;
    if (hdr == 2'b00 || (SWAP && is_wr)) begin
      exp_re[t0 + 10]   = 1'b1;
      exp_addr[t0 + 10] = word;
      old = ref_mem[word];
      sched_reply(t0 + 11, old);
    end
    if (is_wr) begin
      exp_we[t0 + 18]   = 1'b1;
      exp_addr[t0 + 18] = word;
      if (hdr == 2'b10) begin
        exp_be[t0 + 18]    = 2'b11;
        exp_wdata[t0 + 18] = data;
        ref_mem[word]      = data;
      end else begin
        exp_be[t0 + 18]    = addr[0] ? 2'b10 : 2'b01;
        exp_wdata[t0 + 18] = {data[7:0], data[7:0]};
        if (addr[0]) ref_mem[word][15:8] = data[7:0];
        else         ref_mem[word][7:0]  = data[7:0];
      end
    end
  endtask

  // ---------------- per-cycle compare (with reply deserializer) ----------------
  int          rcv_cnt = 0;
  logic [15:0] rcv_word = '0;

  task automatic check_cycle(input int c);
    chk("rx_pins", c, 32'(rx_pins), 32'(exp_rx[c]));
    chk("mem_re",  c, 32'(mem_re),  32'(exp_re[c]));
    chk("mem_we",  c, 32'(mem_we),  32'(exp_we[c]));
    chk("err_hdr", c, 32'(err_hdr), 32'(exp_err[c]));
    chk("busy",    c, 32'(busy),    32'(exp_busy[c]));
    if (exp_re[c] || exp_we[c]) chk("mem_addr", c, 32'(mem_addr), 32'(exp_addr[c]));
    if (exp_we[c]) begin
      chk("mem_be",    c, 32'(mem_be),    32'(exp_be[c]));
      chk("mem_wdata", c, 32'(mem_wdata), 32'(exp_wdata[c]));
    end
    if (rcv_cnt > 0) begin
      rcv_word = {rx_pins, rcv_word[15:2]};
      rcv_cnt--;
      if (rcv_cnt == 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL reply_word cycle=%0d got=%0h expected=none", c, rcv_word);
        end else begin
          chk("reply_word", c, 32'(rcv_word), 32'(exp_q.pop_front()));
        end
      end
    end else if (rx_pins == 2'b01) begin
      rcv_cnt = 8;
    end
  endtask

  // ---------------- main ----------------
  initial begin
    logic [1:0]  lit [8];
    logic [1:0]  hdr;
    int          t, accept, gap;
    reset   = 1'b1;
    tx_pins = 2'b00;
    seed    = 16'($urandom);
    for (int i = 0; i < 32768; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < N; i++) begin
      tx_arr[i] = 2'b00; rst_arr[i] = (i < 4); exp_rx[i] = 2'b00;
      exp_re[i] = 1'b0; exp_we[i] = 1'b0; exp_err[i] = 1'b0; exp_busy[i] = 1'b0;
      exp_addr[i] = '0; exp_be[i] = '0; exp_wdata[i] = '0;
    end

    // Directed scenarios
    add_msg(6,   2'b00, 16'h1234, 16'h0000, 0);            // READ 0x1234 -> 0xBEEF
    add_msg(30,  2'b11, 16'h0456, 16'h0000, 0);            // reserved header
    add_msg(40,  2'b00, 16'h0042, 16'h0000, 0);            // read at reserved's T10
    add_msg(70,  2'b01, 16'h0021, 16'h005A, 0);            // WRITE_8 high byte
    add_msg(88,  2'b00, 16'h0020, 16'h0000, 0);            // read back at T18
    add_msg(110, 2'b10, 16'h0304, 16'($urandom), 115);     // WRITE_16 reset at T5
    add_msg(117, 2'b00, 16'h0100, 16'h0000, 0);            // read 2 cycles later
    add_msg(150, 2'b00, 16'h0012, 16'h0000, 0);            // back-to-back reads
    add_msg(160, 2'b00, 16'h0034, 16'h0000, 0);
    add_msg(190, 2'b10, 16'h0500, 16'h1111, 0);            // WRITE_16 over 0x2222

    // Randomized traffic on a small address window
    t = 220;
    for (int m = 0; m < 40; m++) begin
      hdr = 2'($urandom_range(0, 3));
      add_msg(t, hdr, 16'($urandom_range(0, 63)), 16'($urandom), 0);
      accept = (hdr == 2'b01 || hdr == 2'b10) ? t + 18 : t + 10;
      gap    = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tx_arr[accept + g] = {1'($urandom_range(0, 1)), 1'b0};
      t = accept + gap;
    end
    end_cyc = t + 40;

    // Hand-computed pins on the model
    lit = '{2'd3, 2'd3, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3, 2'd2};
    chk("pin_re_T10",   16, 32'(exp_re[16]),   32'd1);
    chk("pin_addr_T10", 16, 32'(exp_addr[16]), 32'h091A);
    chk("pin_rx_start", 18, 32'(exp_rx[18]),   32'd1);
    for (int k = 0; k < 8; k++) chk("pin_rx_data", 19 + k, 32'(exp_rx[19 + k]), 32'(lit[k]));
    chk("pin_rx_after", 27, 32'(exp_rx[27]),   32'd0);
    chk("pin_err_T10",  40, 32'(exp_err[40]),  32'd1);
    chk("pin_we_T18",   88, 32'(exp_we[88]),   32'd1);
    chk("pin_be_T18",   88, 32'(exp_be[88]),   32'd2);
    chk("pin_wd_T18",   88, 32'(exp_wdata[88][15:8]), 32'h5A);
    chk("pin_b2b_2nd",  172, 32'(exp_rx[172]), 32'd1);

    // Run: drive after each rising edge, compare on the falling edge
    for (int c = 0; c < end_cyc; c++) begin
      @(posedge clk);
      #1;
      tx_pins = tx_arr[c];
      reset   = rst_arr[c];
      @(negedge clk);
      check_cycle(c);
    end

    // End-state checks
    chk("replies_outstanding", end_cyc, 32'(exp_q.size()), 32'd0);
    chk("swap_word_final", end_cyc, 32'(ram['h280]), 32'h1111);
    chk("byte_write_word", end_cyc, 32'(ram['h10]),  32'(ref_mem['h10]));
    for (int w = 0; w < 32; w++) chk("ram_word", w, 32'(ram[w]), 32'(ref_mem[w]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
